// File: rtl/ntt_dif_shoup_param.sv
// In-place radix-2 decimation-in-frequency NTT engine with Shoup twiddle
// multiplication. Run-time transform length 2^L (L <= LOG_N); data in vector
// RAM addresses 0..2^L-1 in natural order, result left bit-reversed.
// One butterfly every four cycles: read, wait, compute, write.
module ntt_dif_shoup_param #(
   parameter int WIDTH = 32,
   parameter int LOG_N = 12,
   parameter int NLW   = $clog2(LOG_N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_rsc_vld,
   output logic             run_rsc_rdy,
   input  logic [NLW-1:0]   n_log_dat,
   input  logic [WIDTH-1:0] p_rsc_dat,
   output logic [LOG_N-1:0] vec_rsc_adra,
   output logic [WIDTH-1:0] vec_rsc_da,
   output logic             vec_rsc_wea,
   input  logic [WIDTH-1:0] vec_rsc_qa,
   output logic [LOG_N-1:0] vec_rsc_adrb,
   output logic [WIDTH-1:0] vec_rsc_db,
   output logic             vec_rsc_web,
   input  logic [WIDTH-1:0] vec_rsc_qb,
   output logic [LOG_N-2:0] twiddle_rsc_adr,
   input  logic [WIDTH-1:0] twiddle_rsc_q,
   input  logic [WIDTH-1:0] twiddle_h_rsc_q,
   output logic             complete_rsc_vld,
   input  logic             complete_rsc_rdy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_CMP,
      S_WR,
      S_DONE
   } state_t;

   state_t state_reg, state_next;
   logic [NLW-1:0]   s_reg, s_next;       // stage
   logic [LOG_N-2:0] k_reg, k_next;       // butterfly within stage
   logic [NLW-1:0]   l_reg, l_next;       // latched log2 length
   logic [WIDTH-1:0] p_reg, p_next;       // latched modulus

   logic [WIDTH-1:0] a_reg, b_reg, w_reg, wh_reg;
   logic [WIDTH-1:0] sum_reg, r_reg;
   logic [WIDTH-1:0] sum_next, r_next;

   // Address generation signals
   logic [NLW-1:0]   l_sel;     // requested length clamped to LOG_N
   logic [NLW-1:0]   sh;        // log2(half) = L-1-s
   logic [NLW-1:0]   lm1;       // L-1
   logic [NLW:0]     tsh;       // twiddle stride shift = s + LOG_N - L
   logic [LOG_N-1:0] i0, i1, half;
   logic [LOG_N-2:0] j_mask, j, t, k_max;
   logic             k_last, s_last;

   assign l_sel  = (n_log_dat > NLW'(LOG_N)) ? NLW'(LOG_N) : n_log_dat;
   assign lm1    = l_reg - NLW'(1);
   assign sh     = lm1 - s_reg;
   assign tsh    = (NLW+1)'(s_reg) + (NLW+1)'(LOG_N) - (NLW+1)'(l_reg);
   assign half   = LOG_N'(1) << sh;
   assign i1     = i0 | half;
   assign j      = k_reg & j_mask;
   assign t      = j << tsh;
   assign k_last = (k_reg == k_max);
   assign s_last = (s_reg == lm1);

   // i0 is k with a zero bit inserted at position sh (g*2*half + j);
   // j_mask selects the low sh bits of k; k_max = 2^(L-1)-1.
   genvar gi;
   generate
      for (gi = 0; gi < LOG_N; gi++) begin : g_addr
         if (gi == 0) begin : g_lsb
            assign i0[gi] = (sh == '0) ? 1'b0 : k_reg[gi];
         end else if (gi == LOG_N - 1) begin : g_msb
            assign i0[gi] = (sh == NLW'(gi)) ? 1'b0 : k_reg[gi-1];
         end else begin : g_mid
            assign i0[gi] = (NLW'(gi) < sh) ? k_reg[gi] :
                            ((NLW'(gi) == sh) ? 1'b0 : k_reg[gi-1]);
         end
         if (gi < LOG_N - 1) begin : g_mask
            assign j_mask[gi] = (NLW'(gi) < sh);
            assign k_max[gi]  = (NLW'(gi) < lm1);
         end
      end
   endgenerate

   // FSM and loop counters: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         s_reg     <= '0;
         k_reg     <= '0;
         l_reg     <= '0;
         p_reg     <= '0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         k_reg     <= k_next;
         l_reg     <= l_next;
         p_reg     <= p_next;
      end
   end

   // FSM next state, loop advance and run-time configuration capture
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      k_next     = k_reg;
      l_next     = l_reg;
      p_next     = p_reg;
      case (state_reg)
         S_IDLE: begin
            if (run_rsc_vld) begin
               l_next     = l_sel;
               p_next     = p_rsc_dat;
               s_next     = '0;
               k_next     = '0;
               state_next = (l_sel == '0) ? S_DONE : S_RD;
            end
         end
         S_RD:  state_next = S_WT;
         S_WT:  state_next = S_CMP;
         S_CMP: state_next = S_WR;
         S_WR: begin
            state_next = S_RD;
            if (k_last) begin
               k_next = '0;
               if (s_last) begin
                  s_next     = '0;
                  state_next = S_DONE;
               end else begin
                  s_next = s_reg + NLW'(1);
               end
            end else begin
               k_next = k_reg + (LOG_N-1)'(1);
            end
         end
         S_DONE: begin
            if (complete_rsc_rdy) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Butterfly arithmetic: modular add, modular subtract, Shoup multiply
   logic [WIDTH:0]   sum_full;
   logic [WIDTH-1:0] diff, quo, rem;
   always_comb begin
      sum_full = {1'b0, a_reg} + {1'b0, b_reg};
      sum_next = (sum_full >= {1'b0, p_reg}) ? WIDTH'(sum_full - {1'b0, p_reg})
                                             : WIDTH'(sum_full);
      diff = a_reg - b_reg;
      if (a_reg < b_reg) begin
         diff = diff + p_reg;
      end
      quo    = WIDTH'(({{WIDTH{1'b0}}, diff} * {{WIDTH{1'b0}}, wh_reg}) >> WIDTH);
      rem    = diff * w_reg - quo * p_reg;
      r_next = (rem >= p_reg) ? rem - p_reg : rem;
   end

   // Datapath registers: capture operands in WT, results in CMP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         w_reg   <= '0;
         wh_reg  <= '0;
         sum_reg <= '0;
         r_reg   <= '0;
      end else begin
         if (state_reg == S_WT) begin
            a_reg  <= vec_rsc_qa;
            b_reg  <= vec_rsc_qb;
            w_reg  <= twiddle_rsc_q;
            wh_reg <= twiddle_h_rsc_q;
         end
         if (state_reg == S_CMP) begin
            sum_reg <= sum_next;
            r_reg   <= r_next;
         end
      end
   end

   // Memory and handshake outputs decoded from state; idle values are zero
   always_comb begin
      vec_rsc_adra     = '0;
      vec_rsc_da       = '0;
      vec_rsc_wea      = 1'b0;
      vec_rsc_adrb     = '0;
      vec_rsc_db       = '0;
      vec_rsc_web      = 1'b0;
      twiddle_rsc_adr  = '0;
      run_rsc_rdy      = (state_reg == S_IDLE);
      complete_rsc_vld = (state_reg == S_DONE);
      case (state_reg)
         S_RD: begin
            vec_rsc_adra    = i0;
            vec_rsc_adrb    = i1;
            twiddle_rsc_adr = t;
         end
         S_WR: begin
            vec_rsc_adra = i0;
            vec_rsc_da   = sum_reg;
            vec_rsc_wea  = 1'b1;
            vec_rsc_adrb = i1;
            vec_rsc_db   = r_reg;
            vec_rsc_web  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ntt_dif_shoup_param.sv
// Testbench for ntt_dif_shoup_param: behavioural dual-port vector RAM and
// twiddle ROMs, a scoreboard of expected butterfly writes produced by a
// plain modular-arithmetic DIF model, and directed length/handshake cases.
module tb_ntt_dif_shoup_param;

   localparam int WIDTH = 32;
   localparam int LOG_N = 6;
   localparam int NLW   = $clog2(LOG_N + 1);
   localparam int N     = 1 << LOG_N;
   localparam longint unsigned PBIG = 64'h7FFFE001;

   logic             clk = 1'b0;
   logic             rst;
   logic             run_rsc_vld, run_rsc_rdy;
   logic [NLW-1:0]   n_log_dat;
   logic [WIDTH-1:0] p_rsc_dat;
   logic [LOG_N-1:0] vec_rsc_adra, vec_rsc_adrb;
   logic [WIDTH-1:0] vec_rsc_da, vec_rsc_db, vec_rsc_qa, vec_rsc_qb;
   logic             vec_rsc_wea, vec_rsc_web;
   logic [LOG_N-2:0] twiddle_rsc_adr;
   logic [WIDTH-1:0] twiddle_rsc_q, twiddle_h_rsc_q;
   logic             complete_rsc_vld, complete_rsc_rdy;

   // loader port into the vector RAM, used only while the engine is idle
   logic             ld_we;
   logic [LOG_N-1:0] ld_adr;
   logic [WIDTH-1:0] ld_dat;

   logic [WIDTH-1:0] vec [N];
   logic [WIDTH-1:0] tw  [N/2];
   logic [WIDTH-1:0] twh [N/2];
   logic [WIDTH-1:0] init_v [N];
   longint unsigned  mdl [N];

   typedef struct packed {
      logic [LOG_N-1:0] a0;
      logic [WIDTH-1:0] d0;
      logic [LOG_N-1:0] a1;
      logic [WIDTH-1:0] d1;
   } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ntt_dif_shoup_param #(.WIDTH(WIDTH), .LOG_N(LOG_N), .NLW(NLW)) dut (
      .clk              (clk),
      .rst              (rst),
      .run_rsc_vld      (run_rsc_vld),
      .run_rsc_rdy      (run_rsc_rdy),
      .n_log_dat        (n_log_dat),
      .p_rsc_dat        (p_rsc_dat),
      .vec_rsc_adra     (vec_rsc_adra),
      .vec_rsc_da       (vec_rsc_da),
      .vec_rsc_wea      (vec_rsc_wea),
      .vec_rsc_qa       (vec_rsc_qa),
      .vec_rsc_adrb     (vec_rsc_adrb),
      .vec_rsc_db       (vec_rsc_db),
      .vec_rsc_web      (vec_rsc_web),
      .vec_rsc_qb       (vec_rsc_qb),
      .twiddle_rsc_adr  (twiddle_rsc_adr),
      .twiddle_rsc_q    (twiddle_rsc_q),
      .twiddle_h_rsc_q  (twiddle_h_rsc_q),
      .complete_rsc_vld (complete_rsc_vld),
      .complete_rsc_rdy (complete_rsc_rdy)
   );

   // synchronous memories with one-cycle read latency
   always @(posedge clk) begin
      if (ld_we) vec[ld_adr] <= ld_dat;
      if (vec_rsc_wea) vec[vec_rsc_adra] <= vec_rsc_da;
      if (vec_rsc_web) vec[vec_rsc_adrb] <= vec_rsc_db;
      vec_rsc_qa      <= vec[vec_rsc_adra];
      vec_rsc_qb      <= vec[vec_rsc_adrb];
      twiddle_rsc_q   <= tw[twiddle_rsc_adr];
      twiddle_h_rsc_q <= twh[twiddle_rsc_adr];
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // every write cycle must match the next expected butterfly write
   always @(negedge clk) begin
      if (vec_rsc_wea || vec_rsc_web) begin
         check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("wr_en",   64'({vec_rsc_wea, vec_rsc_web}), 64'd3);
            check_eq("wr_adra", 64'(vec_rsc_adra), 64'(mon_e.a0));
            check_eq("wr_da",   64'(vec_rsc_da),   64'(mon_e.d0));
            check_eq("wr_adrb", 64'(vec_rsc_adrb), 64'(mon_e.a1));
            check_eq("wr_db",   64'(vec_rsc_db),   64'(mon_e.d1));
         end
      end
   end

   task automatic set_twiddle(input int idx, input longint unsigned w, input longint unsigned p);
      tw[idx]  = WIDTH'(w);
      twh[idx] = WIDTH'((w << WIDTH) / p);
   endtask

   // reference DIF transform on mdl[], queueing each butterfly's write
   task automatic run_model(input int l, input longint unsigned p);
      int half, j, g, i0, i1, t;
      longint unsigned a, b, sm, r;
      wr_t e;
      for (int s = 0; s < l; s++) begin
         half = 1 << (l - 1 - s);
         for (int k = 0; k < (1 << (l - 1)); k++) begin
            j  = k % half;
            g  = k / half;
            i0 = g * 2 * half + j;
            i1 = i0 + half;
            t  = j << (s + LOG_N - l);
            a  = mdl[i0];
            b  = mdl[i1];
            sm = (a + b) % p;
            r  = (((a + p - b) % p) * 64'(tw[t])) % p;
            mdl[i0] = sm;
            mdl[i1] = r;
            e.a0 = LOG_N'(i0);
            e.d0 = WIDTH'(sm);
            e.a1 = LOG_N'(i1);
            e.d1 = WIDTH'(r);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic load_vec(input int m);
      for (int i = 0; i < m; i++) begin
         @(negedge clk);
         ld_we  = 1'b1;
         ld_adr = LOG_N'(i);
         ld_dat = init_v[i];
         mdl[i] = 64'(init_v[i]);
      end
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   task automatic fill_random(input longint unsigned p);
      for (int i = 0; i < N; i++) init_v[i] = WIDTH'(64'($urandom) % p);
      for (int i = 0; i < N/2; i++) set_twiddle(i, 64'($urandom) % p, p);
   endtask

   // one complete run: accept, wait for completion, handshake, check memory
   task automatic do_run(input int nlog, input int l, input longint unsigned p,
                         input int hold, input bit stray);
      int cyc;
      bit ok;
      exp_q.delete();
      run_model(l, p);
      @(negedge clk);
      check_eq("run_rdy_idle", 64'(run_rsc_rdy), 64'd1);
      run_rsc_vld      = 1'b1;
      n_log_dat        = NLW'(nlog);
      p_rsc_dat        = WIDTH'(p);
      complete_rsc_rdy = (hold == 0);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            check_eq("run_rdy_busy", 64'(run_rsc_rdy), 64'd0);
            n_log_dat = NLW'($urandom);
            p_rsc_dat = WIDTH'($urandom);
            if (!stray) run_rsc_vld = 1'b0;
         end
         if (cyc == 3) run_rsc_vld = 1'b0;
      end while (complete_rsc_vld !== 1'b1 && cyc < 5000);
      run_rsc_vld = 1'b0;
      check_eq("latency", 64'(cyc), 64'(4 * l * ((1 << l) / 2) + 1));
      if (hold > 0) begin
         ok = 1'b1;
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (!(complete_rsc_vld === 1'b1 && run_rsc_rdy === 1'b0)) ok = 1'b0;
         end
         check_eq("done_hold", 64'(ok), 64'd1);
         complete_rsc_rdy = 1'b1;
      end
      @(posedge clk);
      #1;
      check_eq("idle_rdy", 64'(run_rsc_rdy), 64'd1);
      check_eq("idle_vld", 64'(complete_rsc_vld), 64'd0);
      complete_rsc_rdy = 1'b0;
      check_eq("wr_left", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < (1 << l); i++) check_eq("mem", 64'(vec[i]), mdl[i]);
      $display("run n_log=%0d L=%0d p=%0d hold=%0d cycles=%0d", nlog, l, p, hold, cyc);
   endtask

   initial begin
      $display("watchdog armed");
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      run_rsc_vld = 1'b0;
      n_log_dat = '0;
      p_rsc_dat = '0;
      complete_rsc_rdy = 1'b0;
      ld_we = 1'b0;
      ld_adr = '0;
      ld_dat = '0;
      for (int i = 0; i < N/2; i++) set_twiddle(i, 1, 17);

      repeat (3) @(negedge clk);
      check_eq("rst_run_rdy", 64'(run_rsc_rdy), 64'd1);
      check_eq("rst_cmp_vld", 64'(complete_rsc_vld), 64'd0);
      check_eq("rst_we", 64'({vec_rsc_wea, vec_rsc_web}), 64'd0);
      check_eq("rst_addr", 64'({vec_rsc_adra, vec_rsc_adrb, twiddle_rsc_adr}), 64'd0);
      rst = 1'b1;

      // L=1, p=17: (3,5) -> (8,15); stray run request while busy
      init_v[0] = 3;
      init_v[1] = 5;
      set_twiddle(0, 1, 17);
      load_vec(2);
      do_run(1, 1, 17, 0, 1'b1);
      check_eq("l1_v0", 64'(vec[0]), 64'd8);
      check_eq("l1_v1", 64'(vec[1]), 64'd15);

      // L=2, w=4 (4th root mod 17, table entry 16 with LOG_N=6).
      // Natural-order NTT of 1,2,3,4 is 10,7,15,6; bit-reversed 10,15,7,6.
      init_v[0] = 1; init_v[1] = 2; init_v[2] = 3; init_v[3] = 4;
      set_twiddle(0, 1, 17);
      set_twiddle(16, 4, 17);
      load_vec(4);
      do_run(2, 2, 17, 10, 1'b0);
      check_eq("l2_v0", 64'(vec[0]), 64'd10);
      check_eq("l2_v1", 64'(vec[1]), 64'd15);
      check_eq("l2_v2", 64'(vec[2]), 64'd7);
      check_eq("l2_v3", 64'(vec[3]), 64'd6);

      // L=0: no memory writes, completes one cycle after accept
      do_run(0, 0, 17, 0, 1'b0);
      check_eq("l0_v0", 64'(vec[0]), 64'd10);

      // oversized length request is clamped to LOG_N
      fill_random(PBIG);
      load_vec(N);
      do_run(7, LOG_N, PBIG, 0, 1'b0);

      // asynchronous reset in the middle of a full-size run
      fill_random(PBIG);
      load_vec(N);
      exp_q.delete();
      run_model(LOG_N, PBIG);
      @(negedge clk);
      run_rsc_vld = 1'b1;
      n_log_dat   = NLW'(LOG_N);
      p_rsc_dat   = WIDTH'(PBIG);
      @(posedge clk);
      #1;
      run_rsc_vld = 1'b0;
      repeat (151) @(posedge clk);
      #3;
      check_eq("pre_rst_wea", 64'(vec_rsc_wea), 64'd1);
      rst = 1'b0;
      #1;
      check_eq("arst_run_rdy", 64'(run_rsc_rdy), 64'd1);
      check_eq("arst_cmp_vld", 64'(complete_rsc_vld), 64'd0);
      check_eq("arst_we", 64'({vec_rsc_wea, vec_rsc_web}), 64'd0);
      check_eq("arst_addr", 64'({vec_rsc_adra, vec_rsc_adrb, twiddle_rsc_adr}), 64'd0);
      check_eq("arst_data", {vec_rsc_da, vec_rsc_db}, 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // fresh full-size run after the abort
      fill_random(PBIG);
      load_vec(N);
      do_run(LOG_N, LOG_N, PBIG, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
